multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle sequencing FSM for the RV32I core.
- Drives IR/PC write enables, instruction- and data-memory request handshakes, register-file write enable, PC-source select and write-back select.
- Consumes the combinational decoder's control outputs and the ALU branch-taken flag.
- Sits between the decoder/ALU/register file and the two memory ports. Also keeps the retired-instruction count and latches the fault code.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles on any memory request before a fault is raised.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue enable; sampled only in FETCH.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction data valid; accepted while imem_req=1.
- ir_we  out  1  one-cycle pulse that loads the instruction register.
- dec_reg_write  in  1  decoder register-write flag.
- dec_jal  in  1  decoder JAL flag.
- dec_jalr  in  1  decoder JALR flag.
- dec_branch  in  1  decoder branch flag.
- dec_mem_store  in  2  store size: 00=B, 01=H, 10=W, 11=no store.
- dec_mem_load  in  3  load type: 000=LB, 001=LH, 010=LW, 011=LBU, 100=LHU, 111=no load.
- dec_alu_code  in  6  decoded ALU operation; ALU_NOP means illegal.
- br_taken  in  1  ALU branch comparison result.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1=store, 0=load; valid while dmem_req=1.
- dmem_ready  in  1  data access complete.
- rf_we  out  1  register-file write enable.
- wb_sel  out  2  write-back source: 0=ALU, 1=load data, 2=PC+4.
- pc_we  out  1  PC update enable.
- pc_sel  out  2  next-PC source: 0=PC+4, 1=PC+imm (taken branch or JAL), 2=(rs1+imm)&~1 (JALR).
- halted  out  1  FSM is in HALT.
- fault  out  2  0=none, 1=illegal instruction, 2=imem timeout, 3=dmem timeout.
- instret  out  CNT_W  retired instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH with the request not yet issued.
  - All outputs 0, including instret, fault, halted, wb_sel and pc_sel.
  - Reset mid-handshake abandons the access immediately; no retire occurs.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - If run=0: imem_req=0, stay in FETCH.
  - If run=1: imem_req=1, held until imem_ready=1.
  - On the ready cycle: ir_we=1 for that cycle, go to DECODE. A ready in the same cycle the request first rises is accepted.
  - Once imem_req is high, run is ignored until the handshake completes.
- DECODE: one cycle for the decoder to settle on the new IR.
  - If dec_alu_code==ALU_NOP: fault=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - If dec_mem_load!=111 or dec_mem_store!=11: go to MEM.
  - Otherwise go to WB.
  - br_taken is sampled and registered here for use in WB.
- MEM:
  - dmem_req=1; dmem_we=1 iff dec_mem_store!=11.
  - Held until dmem_ready=1, then go to WB.
  - dmem_we must stay stable while the request is pending.
- WB: one cycle.
  - pc_we=1.
  - rf_we=dec_reg_write. Stores and branches therefore produce rf_we=0.
  - wb_sel: 2 if jal or jalr; else 1 if a load; else 0.
  - pc_sel: 2 if jalr; 1 if jal, or if branch with registered br_taken=1; else 0.
  - instret increments by 1 and wraps modulo 2^CNT_W.
  - Next state FETCH.
- HALT:
  - All strobes 0 (imem_req, dmem_req, ir_we, rf_we, pc_we).
  - halted=1; fault keeps its value.
  - Only exit is rst_n.
- Timeout:
  - An 8-bit-or-wider wait counter clears on entry to FETCH or MEM.
  - It counts each cycle a request is high without ready.
  - If the count reaches MEM_TIMEOUT with ready still 0: request drops, fault=2 (FETCH) or 3 (MEM), go to HALT.
  - Ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: no fault.
- wb_sel and pc_sel are don't-care (driven 0) outside WB.
- All outputs are decoded from the registered state and registered flags. No input drives an output through to the same cycle, except ir_we, which follows imem_ready in FETCH.
- Latency with zero-wait memory: ALU or branch instruction 4 cycles; load or store 5 cycles.

Decomposition:
- Opcode and ALU_* codes (including ALU_NOP) come from the shared define.vh.
- Add to define.vh: state encodings (CTRL_FETCH … CTRL_HALT), FAULT_* codes, WB_SEL_* and PC_SEL_* values, MEM_STORE_NONE=2'b11, MEM_LOAD_NONE=3'b111.
- One natural sub-module: wait_timer. It takes clk, rst_n, clr and count-enable, and outputs expired; it is instantiated once and shared by FETCH and MEM.

Test Plan:
- ADD, zero-wait memories, run=1 → ir_we at cycle 1; WB at cycle 4 with rf_we=1, wb_sel=0, pc_sel=0; instret=1.
- LW with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0; then WB with rf_we=1, wb_sel=1; total 8 cycles.
- Two branches: BEQ with br_taken=1 gives pc_sel=1, rf_we=0. BNE with br_taken=0 gives pc_sel=0. JALR gives pc_sel=2, wb_sel=2, rf_we=1.
- SW → dmem_we=1 throughout MEM; rf_we=0 in WB; instret increments.
- Illegal instruction: decoder reports ALU_NOP → halted=1, fault=1 two cycles after ir_we; no further imem_req; instret unchanged.
- imem_ready stuck at 0 with MEM_TIMEOUT=4 → fault=2 and halted after 4 wait cycles. Separately, assert rst_n=0 mid-wait → all outputs return to 0 immediately and fetch restarts cleanly.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, ALU codes,
// sequencer states, fault codes and the write-back / next-PC select values.
package multicycle_ctrl_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Decoded ALU operations; ALU_NOP marks an instruction the decoder rejected
  localparam int unsigned ALU_W = 6;
  localparam logic [ALU_W-1:0] ALU_NOP  = 6'h00;
  localparam logic [ALU_W-1:0] ALU_ADD  = 6'h01;
  localparam logic [ALU_W-1:0] ALU_SUB  = 6'h02;
  localparam logic [ALU_W-1:0] ALU_SLL  = 6'h03;
  localparam logic [ALU_W-1:0] ALU_SLT  = 6'h04;
  localparam logic [ALU_W-1:0] ALU_SLTU = 6'h05;
  localparam logic [ALU_W-1:0] ALU_XOR  = 6'h06;
  localparam logic [ALU_W-1:0] ALU_SRL  = 6'h07;
  localparam logic [ALU_W-1:0] ALU_SRA  = 6'h08;
  localparam logic [ALU_W-1:0] ALU_OR   = 6'h09;
  localparam logic [ALU_W-1:0] ALU_AND  = 6'h0A;
  localparam logic [ALU_W-1:0] ALU_BEQ  = 6'h10;
  localparam logic [ALU_W-1:0] ALU_BNE  = 6'h11;
  localparam logic [ALU_W-1:0] ALU_BLT  = 6'h12;
  localparam logic [ALU_W-1:0] ALU_BGE  = 6'h13;
  localparam logic [ALU_W-1:0] ALU_BLTU = 6'h14;
  localparam logic [ALU_W-1:0] ALU_BGEU = 6'h15;
  localparam logic [ALU_W-1:0] ALU_LUI  = 6'h16;

  // Sequencer states
  typedef enum logic [2:0] {
    CTRL_FETCH  = 3'd0,
    CTRL_DECODE = 3'd1,
    CTRL_EXEC   = 3'd2,
    CTRL_MEM    = 3'd3,
    CTRL_WB     = 3'd4,
    CTRL_HALT   = 3'd5
  } ctrl_state_e;

  // Latched fault cause, visible once the sequencer halts
  typedef enum logic [1:0] {
    FAULT_NONE         = 2'd0,
    FAULT_ILLEGAL      = 2'd1,
    FAULT_IMEM_TIMEOUT = 2'd2,
    FAULT_DMEM_TIMEOUT = 2'd3
  } fault_e;

  // Write-back source and next-PC source selects
  localparam logic [1:0] WB_SEL_ALU    = 2'd0;
  localparam logic [1:0] WB_SEL_MEM    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;
  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  // Decoder "no memory access" markers
  localparam logic [1:0] MEM_STORE_NONE = 2'b11;
  localparam logic [2:0] MEM_LOAD_NONE  = 3'b111;

  // Strobes asserted together during the write-back cycle
  typedef struct packed {
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] pc_sel;
  } wb_ctrl_t;

  // Wait counter is at least 8 bits and always wide enough for the timeout
  function automatic int unsigned timer_width(input int unsigned limit);
    return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait timer shared by the fetch and data-access handshakes.
// expired fires in the waiting cycle whose count step would reach LIMIT, so a
// ready arriving in that same cycle (which suppresses en) still wins.
module wait_timer #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  // Count cycles spent waiting on a pending request; idle periods clear it
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = cnt_en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32I core: FETCH -> DECODE -> EXEC -> [MEM] ->
// WB, with memory-handshake timeouts, an illegal-instruction halt, a retired
// instruction counter and a latched fault code. Every output comes from
// registered state except ir_we, which tracks imem_ready during a fetch.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic             dec_reg_write,
  input  logic             dec_jal,
  input  logic             dec_jalr,
  input  logic             dec_branch,
  input  logic [1:0]       dec_mem_store,
  input  logic [2:0]       dec_mem_load,
  input  logic [5:0]       dec_alu_code,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned TIMER_W = timer_width(MEM_TIMEOUT);

  ctrl_state_e      state_q;
  logic             imem_req_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             br_taken_q;
  logic             pc_we_q;
  wb_ctrl_t         wb_q;
  fault_e           fault_q;
  logic [CNT_W-1:0] instret_q;

  logic     is_load;
  logic     is_store;
  logic     mem_access;
  logic     taken_d;
  logic     wb_entry;
  logic     wait_clr;
  logic     wait_en;
  logic     wait_expired;
  wb_ctrl_t wb_ctrl_d;

  // Decode the write-back controls and handshake helpers for the next edge
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_load    = (dec_mem_load != MEM_LOAD_NONE);
    is_store   = (dec_mem_store != MEM_STORE_NONE);
    mem_access = is_load || is_store;
    // Going straight EXEC -> WB uses the live flag; after MEM use the copy taken in EXEC
    taken_d    = (state_q == CTRL_EXEC) ? br_taken : br_taken_q;

    wb_ctrl_d        = '0;
    wb_ctrl_d.rf_we  = dec_reg_write;
    if (dec_jal || dec_jalr) begin
      wb_ctrl_d.wb_sel = WB_SEL_PC4;
    end else if (is_load) begin
      wb_ctrl_d.wb_sel = WB_SEL_MEM;
    end
    if (dec_jalr) begin
      wb_ctrl_d.pc_sel = PC_SEL_JALR;
    end else if (dec_jal || (dec_branch && taken_d)) begin
      wb_ctrl_d.pc_sel = PC_SEL_TARGET;
    end

    wb_entry = ((state_q == CTRL_EXEC) && !mem_access) ||
               ((state_q == CTRL_MEM) && dmem_ready);

    wait_clr = !(imem_req_q || dmem_req_q);
    wait_en  = (imem_req_q && !imem_ready) || (dmem_req_q && !dmem_ready);
  end

  wait_timer #(
    .W     (TIMER_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wait_clr),
    .cnt_en_i  (wait_en),
    .expired_o (wait_expired)
  );

  // Sequencer: state, memory requests, write-back strobes, fault and instret
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CTRL_FETCH;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      br_taken_q <= 1'b0;
      pc_we_q    <= 1'b0;
      wb_q       <= '0;
      fault_q    <= FAULT_NONE;
      instret_q  <= '0;
    end else begin
      // Write-back strobes are single-cycle pulses
      pc_we_q <= 1'b0;
      wb_q    <= '0;

      case (state_q)
        CTRL_FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= run;
          end else if (imem_ready) begin
            imem_req_q <= 1'b0;
            state_q    <= CTRL_DECODE;
          end else if (wait_expired) begin
            imem_req_q <= 1'b0;
            fault_q    <= FAULT_IMEM_TIMEOUT;
            state_q    <= CTRL_HALT;
          end
        end

        CTRL_DECODE: begin
          if (dec_alu_code == ALU_NOP) begin
            fault_q <= FAULT_ILLEGAL;
            state_q <= CTRL_HALT;
          end else begin
            state_q <= CTRL_EXEC;
          end
        end

        CTRL_EXEC: begin
          br_taken_q <= br_taken;
          if (mem_access) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store;
            state_q    <= CTRL_MEM;
          end else begin
            state_q <= CTRL_WB;
          end
        end

        CTRL_MEM: begin
          if (dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            state_q    <= CTRL_WB;
          end else if (wait_expired) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            fault_q    <= FAULT_DMEM_TIMEOUT;
            state_q    <= CTRL_HALT;
          end
        end

        CTRL_WB: begin
          instret_q <= instret_q + CNT_W'(1);
          state_q   <= CTRL_FETCH;
        end

        CTRL_HALT: begin
          state_q <= CTRL_HALT;
        end

        default: begin
          state_q <= CTRL_HALT;
        end
      endcase

      if (wb_entry) begin
        pc_we_q <= 1'b1;
        wb_q    <= wb_ctrl_d;
      end
    end
  end

  assign imem_req = imem_req_q;
  assign ir_we    = (state_q == CTRL_FETCH) && imem_req_q && imem_ready;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign rf_we    = wb_q.rf_we;
  assign wb_sel   = wb_q.wb_sel;
  assign pc_sel   = wb_q.pc_sel;
  assign pc_we    = pc_we_q;
  assign halted   = (state_q == CTRL_HALT);
  assign fault    = fault_q;
  assign instret  = instret_q;

endmodule
